lsf_mul_signed_pipe: RTL and testbench

- Parametrised, pipelined signed multiplier with valid/ready handshake, optional round-and-shift, and saturation to a configurable output width.
- Successor to the fixed single-cycle DSP48 multiply wrappers used in the LSF HLS calc blocks (e.g. r-offset barrel).
- Carries a sideband tag through the pipeline alongside each product so hit/segment IDs stay aligned with their results.
- Backpressure-safe: no data loss or duplication under arbitrary out_ready.

---
 rtl/lsf_mul_signed_pipe.sv | 184 ++++++++++++++++++
 tb/tb_lsf_mul_signed_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsf_mul_signed_pipe.sv
// Pipelined signed multiplier with valid/ready flow control, optional
// round-half-up right shift and saturation (or wrap) to the output width.
// A sideband tag travels with every product so IDs stay aligned.
module lsf_mul_signed_pipe #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 21,
    parameter int P_WIDTH   = 38,
    parameter int NUM_STAGE = 3,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 1,
    parameter int SAT       = 1,
    parameter int TAG_WIDTH = 8
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   in_a,
    input  logic signed [B_WIDTH-1:0]   in_b,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [P_WIDTH-1:0]   out_p,
    output logic                        out_sat,
    output logic [TAG_WIDTH-1:0]        out_tag
);

    localparam int W   = A_WIDTH + B_WIDTH;
    // Working width: one bit above the full product so the rounding add
    // cannot overflow, and at least one bit above P_WIDTH for the range test.
    localparam int EW  = (W + 1 > P_WIDTH) ? W + 1 : P_WIDTH + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    // With more than one stage, stage 1 holds raw operands and the result
    // registers occupy the remaining stages.
    localparam int OFS = (NUM_STAGE > 1) ? 1 : 0;
    localparam int NR  = NUM_STAGE - OFS;

    localparam logic signed [EW-1:0] RND =
        (SHIFT > 0 && ROUND != 0) ? ({{(EW-1){1'b0}}, 1'b1} << RSH) : '0;
    localparam logic signed [EW-1:0] MAXV =
        {{(EW-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic [NUM_STAGE-1:0]        vld;
    logic [NUM_STAGE-1:0]        load;
    logic                        armed;

    logic signed [A_WIDTH-1:0]   mul_a;
    logic signed [B_WIDTH-1:0]   mul_b;
    logic [TAG_WIDTH-1:0]        mul_tag;
    logic                        calc_go;

    logic signed [W-1:0]         full;
    logic signed [EW-1:0]        sum;
    logic signed [EW-1:0]        rnd_res;
    logic signed [P_WIDTH-1:0]   calc_p;
    logic                        calc_sat;

    logic signed [P_WIDTH-1:0]   res_p   [NR];
    logic                        res_sat [NR];
    logic [TAG_WIDTH-1:0]        res_tag [NR];

    // A stage may load if it or any later stage is empty, or the output drains;
    // written as a flat OR per stage so no combinational chain loops on itself.
    always_comb begin
        for (int k = 0; k < NUM_STAGE; k++) begin
            load[k] = out_ready;
            for (int j = k; j < NUM_STAGE; j++) begin
                if (!vld[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = armed && load[0];

    // Input acceptance is held off until the first clock edge after reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Valid bits advance stage by stage whenever the receiving stage loads.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld <= '0;
        end else begin
            if (load[0]) begin
                vld[0] <= in_valid && in_ready;
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (load[k]) begin
                    vld[k] <= vld[k-1];
                end
            end
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign mul_a   = in_a;
            assign mul_b   = in_b;
            assign mul_tag = in_tag;
            assign calc_go = in_valid && in_ready;
        end else begin : g_multi
            logic signed [A_WIDTH-1:0] op_a;
            logic signed [B_WIDTH-1:0] op_b;
            logic [TAG_WIDTH-1:0]      op_tag;

            // Operand stage captures each accepted beat.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    op_a   <= '0;
                    op_b   <= '0;
                    op_tag <= '0;
                end else if (in_valid && in_ready) begin
                    op_a   <= in_a;
                    op_b   <= in_b;
                    op_tag <= in_tag;
                end
            end

            assign mul_a   = op_a;
            assign mul_b   = op_b;
            assign mul_tag = op_tag;
            assign calc_go = vld[0] && load[1];
        end
    endgenerate

    // Multiply, round, shift and range-limit the product.
    always_comb begin
        full     = mul_a * mul_b;
        sum      = {{(EW-W){full[W-1]}}, full} + RND;
        rnd_res  = sum >>> SHIFT;
        calc_sat = 1'b0;
        calc_p   = rnd_res[P_WIDTH-1:0];
        if (rnd_res > MAXV) begin
            calc_sat = 1'b1;
            if (SAT != 0) begin
                calc_p = MAXV[P_WIDTH-1:0];
            end
        end else if (rnd_res < MINV) begin
            calc_sat = 1'b1;
            if (SAT != 0) begin
                calc_p = MINV[P_WIDTH-1:0];
            end
        end
    end

    // Result registers: the first captures the arithmetic, later ones shift it
    // along only when the previous stage holds a beat that is moving forward.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int j = 0; j < NR; j++) begin
                res_p[j]   <= '0;
                res_sat[j] <= 1'b0;
                res_tag[j] <= '0;
            end
        end else begin
            if (calc_go) begin
                res_p[0]   <= calc_p;
                res_sat[0] <= calc_sat;
                res_tag[0] <= mul_tag;
            end
            for (int j = 1; j < NR; j++) begin
                if (vld[j-1+OFS] && load[j+OFS]) begin
                    res_p[j]   <= res_p[j-1];
                    res_sat[j] <= res_sat[j-1];
                    res_tag[j] <= res_tag[j-1];
                end
            end
        end
    end

    assign out_valid = vld[NUM_STAGE-1];
    assign out_p     = res_p[NR-1];
    assign out_sat   = res_sat[NR-1];
    assign out_tag   = res_tag[NR-1];

endmodule

// File: tb/tb_lsf_mul_signed_pipe.sv
// Self-checking bench for lsf_mul_signed_pipe: five configurations share one
// input stream; a per-instance scoreboard predicts every result from the
// arithmetic rules, and directed checks cover latency, rounding and reset.
module tb_lsf_mul_signed_pipe;

    typedef struct {
        longint p;
        bit     s;
        int     t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic rdy;
    logic signed [17:0] in_a;
    logic signed [20:0] in_b;
    logic [7:0] in_tag;

    logic signed [37:0] op   [5];
    logic               os   [5];
    logic               ov   [5];
    logic               irdy [5];
    logic [7:0]         ot   [5];

    int checks = 0;
    int errors = 0;
    logic alive_m;
    bit   done;

    int shv [5] = '{0, 0, 4, 4, 3};
    int rdv [5] = '{1, 1, 1, 0, 1};
    int satv[5] = '{1, 0, 1, 1, 1};
    int capv[5] = '{3, 3, 3, 3, 1};

    exp_t sb [5][$];

    bit prev_stall;
    logic signed [37:0] prev_p;
    logic prev_s;
    logic [7:0] prev_t;

    always #5 clk = ~clk;

    lsf_mul_signed_pipe u0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(rdy),
        .out_p(op[0]), .out_sat(os[0]), .out_tag(ot[0]));

    lsf_mul_signed_pipe #(.SAT(0)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(1'b1),
        .out_p(op[1]), .out_sat(os[1]), .out_tag(ot[1]));

    lsf_mul_signed_pipe #(.SHIFT(4), .ROUND(1)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov[2]), .out_ready(1'b1),
        .out_p(op[2]), .out_sat(os[2]), .out_tag(ot[2]));

    lsf_mul_signed_pipe #(.SHIFT(4), .ROUND(0)) u3 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[3]),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov[3]), .out_ready(1'b1),
        .out_p(op[3]), .out_sat(os[3]), .out_tag(ot[3]));

    lsf_mul_signed_pipe #(.NUM_STAGE(1), .SHIFT(3), .ROUND(1)) u4 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[4]),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov[4]), .out_ready(1'b1),
        .out_p(op[4]), .out_sat(os[4]), .out_tag(ot[4]));

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic on plain 64-bit integers, 38-bit output.
    function automatic longint refCalc(input longint a, input longint b, input int sh,
                                       input int rnd, input int sat, output bit clip);
        longint f, r;
        longint hi, lo;
        hi = (longint'(1) <<< 37) - 1;
        lo = -(longint'(1) <<< 37);
        f = a * b;
        if (sh > 0 && rnd != 0) r = (f + (longint'(1) <<< (sh - 1))) >>> sh;
        else                    r = f >>> sh;
        clip = (r > hi) || (r < lo);
        if (clip && sat != 0) r = (r > hi) ? hi : lo;
        else if (clip)        r = (r <<< 26) >>> 26;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive_m <= 1'b0;
        else        alive_m <= 1'b1;
    end

    // Scoreboard and flow-control model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) sb[i].delete();
            prev_stall = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                bit ordy;
                ordy = (i == 0) ? rdy : 1'b1;
                checkOutput($sformatf("u%0d_in_ready", i), irdy[i],
                            alive_m && !(sb[i].size() == capv[i] && !ordy));
            end
            if (prev_stall) begin
                checkOutput("stall_p", op[0], prev_p);
                checkOutput("stall_sat", os[0], prev_s);
                checkOutput("stall_tag", ot[0], prev_t);
            end
            for (int i = 0; i < 5; i++) begin
                bit ordy;
                ordy = (i == 0) ? rdy : 1'b1;
                if (ov[i] && ordy) begin
                    if (sb[i].size() == 0) begin
                        checkOutput($sformatf("u%0d_spurious", i), 1, 0);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        checkOutput($sformatf("u%0d_p", i), op[i], e.p);
                        checkOutput($sformatf("u%0d_sat", i), os[i], e.s);
                        checkOutput($sformatf("u%0d_tag", i), ot[i], e.t);
                    end
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (in_valid && irdy[i]) begin
                    exp_t e;
                    bit c;
                    e.p = refCalc(longint'(in_a), longint'(in_b), shv[i], rdv[i], satv[i], c);
                    e.s = c;
                    e.t = int'(in_tag);
                    sb[i].push_back(e);
                end
            end
            prev_stall = ov[0] && !rdy;
            prev_p = op[0];
            prev_s = os[0];
            prev_t = ot[0];
        end
    end

    // Present one beat and hold it until u0 accepts; in_valid stays high.
    task automatic applyStimulus(input logic signed [17:0] a, input logic signed [20:0] b,
                                 input logic [7:0] t);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = irdy[0];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) checkOutput("accept_timeout", 1, 0);
    endtask

    // Single isolated beat: checks latency and tag, leaves result on the outputs.
    task automatic runDirected(input logic signed [17:0] a, input logic signed [20:0] b,
                               input logic [7:0] t);
        int lat;
        applyStimulus(a, b, t);
        in_valid = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, 3);
        checkOutput("dir_tag", ot[0], t);
    endtask

    task automatic waitDrain();
        int n;
        bit empty;
        n = 0;
        empty = 1'b0;
        while (!empty && n < 300) begin
            empty = 1'b1;
            for (int i = 0; i < 5; i++) if (sb[i].size() != 0) empty = 1'b0;
            if (!empty) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!empty) checkOutput("drain_timeout", 1, 0);
    endtask

    function automatic logic signed [17:0] pickA();
        case ($urandom_range(0, 5))
            0: return 18'h20000;
            1: return 18'h1FFFF;
            2: return 18'h00000;
            3: return 18'h3FFFF;
            default: return 18'($urandom);
        endcase
    endfunction

    function automatic logic signed [20:0] pickB();
        case ($urandom_range(0, 5))
            0: return 21'h100000;
            1: return 21'h0FFFFF;
            2: return 21'h000000;
            3: return 21'h1FFFFF;
            default: return 21'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        bit acc;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        rdy = 1'b1;
        done = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_valid", ov[0], 0);
        checkOutput("rst_p", op[0], 0);
        checkOutput("rst_sat", os[0], 0);
        checkOutput("rst_tag", ot[0], 0);
        checkOutput("rst_in_ready", irdy[0], 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", irdy[0], 1);

        $display("[TB] directed arithmetic");
        runDirected(18'sd3, -21'sd5, 8'hA5);
        checkOutput("mul_3x-5", op[0], -15);
        checkOutput("mul_3x-5_sat", os[0], 0);
        runDirected(18'h20000, 21'h100000, 8'h5A);
        checkOutput("minmin_sat_p", op[0], 64'sd137438953471);
        checkOutput("minmin_sat_flag", os[0], 1);
        checkOutput("minmin_wrap_p", op[1], -64'sd137438953472);
        checkOutput("minmin_wrap_flag", os[1], 1);
        runDirected(18'sd7, 21'sd5, 8'h10);
        checkOutput("rnd_7x5", op[2], 2);
        checkOutput("trn_7x5", op[3], 2);
        runDirected(-18'sd7, 21'sd5, 8'h11);
        checkOutput("rnd_-7x5", op[2], -2);
        checkOutput("trn_-7x5", op[3], -3);
        runDirected(18'sd1, 21'sd8, 8'h12);
        checkOutput("rnd_1x8", op[2], 1);
        checkOutput("trn_1x8", op[3], 0);
        runDirected(18'sd0, 21'h0FFFFF, 8'h13);
        checkOutput("zero_p", op[0], 0);
        checkOutput("zero_sat", os[0], 0);
        waitDrain();

        $display("[TB] throughput");
        cyc = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                in_valid = 1'b1;
                in_a = pickA();
                in_b = pickB();
                in_tag = 8'(i);
            end else begin
                in_valid = 1'b0;
            end
            acc = irdy[0];
            @(posedge clk);
            #1;
            cyc++;
            if (i < 20) checkOutput("tput_ready", acc, 1);
            checkOutput("tput_valid", ov[0], (cyc >= 3 && cyc <= 22));
            if (ov[0]) checkOutput("tput_order", ot[0], cyc - 3);
        end
        waitDrain();

        $display("[TB] backpressure");
        fork
            begin
                for (int i = 0; i < 10; i++) applyStimulus(pickA(), pickB(), 8'(i));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] reset mid-stream");
        applyStimulus(pickA(), pickB(), 8'h01);
        applyStimulus(pickA(), pickB(), 8'h02);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", ov[0], 0);
        checkOutput("mid_rst_p", op[0], 0);
        checkOutput("mid_rst_sat", os[0], 0);
        checkOutput("mid_rst_tag", ot[0], 0);
        checkOutput("mid_rst_in_ready", irdy[0], 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        runDirected(18'sd2, 21'sd2, 8'h33);
        checkOutput("post_rst_p", op[0], 4);
        waitDrain();

        $display("[TB] random stream with random backpressure");
        fork
            begin
                for (int i = 0; i < 300; i++) applyStimulus(pickA(), pickB(), 8'($urandom));
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                int g;
                g = 0;
                while (!done && g < 5000) begin
                    @(posedge clk);
                    #1;
                    rdy = ($urandom_range(0, 3) != 0);
                    g++;
                end
                rdy = 1'b1;
            end
        join
        waitDrain();
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
